pc_jump_sequencer: RTL and testbench
====================================

// Module: pc_jump_sequencer
// PURPOSE
//  Fetch sequencer for the MIPS core: owns the PC, issues one instruction-memory request at a time and holds the fetched word for decode.
//  Computes the next PC from sequential, branch, jump and (optionally) jump-register redirects.
//  Sits between the instruction memory and decode; decode returns redirect info when it accepts an instruction.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word aligned
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  run            in   1   start/continue fetching; sampled only in IDLE
//  imem_req       out  1   instruction-memory request, held until imem_ack
//  imem_addr      out  32  fetch address (= PC while imem_req)
//  imem_ack       in   1   memory accepts request; imem_rdata valid same cycle
//  imem_rdata     in   32  fetched instruction word
//  instr_valid    out  1   instr/instr_pc hold a valid instruction for decode
//  instr          out  32  captured instruction word
//  instr_pc       out  32  address of instr
//  instr_ready    in   1   decode accepts instr this cycle (handshake = valid & ready)
//  branch_taken   in   1   accepted instr is a taken branch
//  branch_offset  in   32  sign-extended 16-bit immediate, in words
//  jump           in   1   accepted instr is J/JAL
//  jump_index     in   26  instr[25:0] of the J-type instruction
//  jr             in   1   accepted instr is JR/JALR (JR_EN only; ignored otherwise)
//  jr_target      in   32  register target for jr (JR_EN only)
//  misalign       out  1   sticky: a jr target had bits[1:0]!=0 (JR_EN only; else tied 0)
// BEHAVIOUR
//  - FSM states: IDLE -> FETCH -> HOLD -> FETCH ...; reset state IDLE.
//  - Reset (async assert): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign=0.
//  - IDLE: imem_req=0; run=1 -> FETCH next cycle; run=0 stays.
//  - FETCH: imem_req=1, imem_addr=pc, stable until imem_ack. On ack: instr<=imem_rdata, instr_pc<=pc, -> HOLD.
//  - HOLD: instr_valid=1, outputs stable until instr_ready. On accept: pc<=next_pc, -> FETCH (-> IDLE if run=0 that cycle).
//  - Fetch latency: ack in 1st FETCH cycle gives instr_valid the following cycle; min 2 cycles/instr.
//  - next_pc (pc4 = instr_pc+4, 32-bit wrap, no carry out), priority jr > jump > branch > seq:
//      jr:     {jr_target[31:2],2'b00}
//      jump:   {pc4[31:28], jump_index, 2'b00}
//      branch: pc4 + {branch_offset[29:0],2'b00}  (mod 2^32)
//      else:   pc4
//  - Redirect inputs sampled only on the accept cycle; ignored otherwise.
//  - Multiple redirects asserted together: highest priority wins, no error.
//  - pc = 32'hFFFF_FFFC sequential -> wraps to 0.
//  - run deasserted in FETCH/HOLD: current transaction completes; no new request is issued after the accept.
//  - rst_n asserted mid-FETCH: imem_req drops immediately (async); the pending ack is dropped.
// CONFIGURATION
//  - JR_EN defined: jr/jr_target honoured; misalign sets when jr wins with jr_target[1:0]!=0 (target still forced aligned); cleared only by reset.
//  - JR_EN undefined: jr/jr_target unused, misalign tied 0, priority jump > branch > seq.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: state encoding (IDLE/FETCH/HOLD), PC_INC=32'd4, WORD_ALIGN mask.
//  - Sub-module: shift_left2_jump forms {jump_index,2'b00}; top concatenates pc4[31:28].
//  - The remainder (FSM, PC reg, next-PC mux, branch adder) is flat in this module.
// TESTING
//  - Reset release, run=1, ack immediate, ready=1 -> addrs 0x0,0x4,0x8; instr_valid every 2nd cycle.
//  - imem_ack delayed 3 cycles -> imem_req/imem_addr stable 3 cycles; instr captured on ack cycle only.
//  - instr_pc=0x0040_0010, jump=1, index=26'h0100008 -> next imem_addr 0x0040_0020.
//  - instr_pc=0x100, branch_taken=1, offset=32'hFFFF_FFFE -> next 0x0FC; branch+jump same cycle -> jump target.
//  - JR_EN: jr=1, jr_target=0x1003 -> imem_addr 0x1000, misalign=1 and stays 1; without JR_EN -> seq 0x104.
//  - rst_n low mid-FETCH, then run again -> imem_req=0 async, restart at RESET_PC; run=0 in HOLD -> IDLE after accept.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS fetch path: fetch FSM states and PC constants.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [31:0] WORD_ALIGN = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_jump_sequencer_if.sv
// Instruction-memory and decode-side signals of the fetch sequencer.
// The master modport is the sequencer; the slave modport is memory plus decode.
interface pc_jump_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        misalign;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign,
        input  imem_ack, imem_rdata, instr_ready,
               branch_taken, branch_offset, jump, jump_index, jr, jr_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign,
        output imem_ack, imem_rdata, instr_ready,
               branch_taken, branch_offset, jump, jump_index, jr, jr_target
    );

endinterface

// File: rtl/pc_jump_sequencer_shift_left2_jump.sv
// Forms the low 28 bits of a J-type target: the 26-bit word index scaled to bytes.
module shift_left2_jump (
    input  logic [25:0] jump_index,
    output logic [27:0] jump_field
);

    assign jump_field = {jump_index, 2'b00};

endmodule

// File: rtl/pc_jump_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, holds the word for decode.
// Optional jump-register support is enabled by defining JR_EN.
module pc_jump_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    pc_jump_sequencer_if.master bus
);

    state_t      state, state_nx;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [31:0] pc4;
    logic [31:0] branch_tgt;
    logic [31:0] next_pc;
    logic [27:0] jump_field;
    logic        capture;
    logic        accept;

    assign capture = (state == FETCH) && bus.imem_ack;
    assign accept  = (state == HOLD) && bus.instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (run)             state_nx = FETCH;
            FETCH:   if (bus.imem_ack)    state_nx = HOLD;
            HOLD:    if (bus.instr_ready) state_nx = run ? FETCH : IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
            end
            if (accept) begin
                pc <= next_pc;
            end
        end
    end

    shift_left2_jump u_shift_left2_jump (
        .jump_index (bus.jump_index),
        .jump_field (jump_field)
    );

    // Redirect targets are relative to the held instruction, not the live PC.
    assign pc4        = instr_pc_q + PC_INC;
    assign branch_tgt = pc4 + {bus.branch_offset[29:0], 2'b00};

    always_comb begin
        next_pc = pc4;
`ifdef JR_EN
        if (bus.jr) begin
            next_pc = bus.jr_target & WORD_ALIGN;
        end else
`endif
        if (bus.jump) begin
            next_pc = {pc4[31:28], jump_field};
        end else if (bus.branch_taken) begin
            next_pc = branch_tgt;
        end
    end

`ifdef JR_EN
    logic misalign_q;
    logic unused_offset_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (accept && bus.jr && (bus.jr_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign bus.misalign     = misalign_q;
    assign unused_offset_hi = ^bus.branch_offset[31:30];
`else
    logic unused_jr;

    assign bus.misalign = 1'b0;
    assign unused_jr    = ^{bus.jr, bus.jr_target, bus.branch_offset[31:30]};
`endif

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state == HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_jump_sequencer.sv
// Self-checking bench for pc_jump_sequencer: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model. Define JR_EN to cover jump-register.
module tb_pc_jump_sequencer;

    logic clk;
    logic rst_n;
    logic run;

    pc_jump_sequencer_if bus ();

    pc_jump_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Next fetch address computed from the ISA rules with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] ipc, input logic br,
                                             input logic [31:0] off, input logic j,
                                             input logic [25:0] idx, input logic jrv,
                                             input logic [31:0] jt);
        logic [31:0] seq;
        seq = ipc + 32'd4;
`ifdef JR_EN
        if (jrv) return jt - (jt % 4);
`else
        if (jrv && 1'b0) return jt;
`endif
        if (j)  return (seq & 32'hF000_0000) + ({6'd0, idx} * 32'd4);
        if (br) return seq + off * 32'd4;
        return seq;
    endfunction

    // Model: what the sequencer is doing (0 waiting for run, 1 requesting, 2 presenting).
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_mis;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_ipc   = 32'h0;
            m_mis   = 1'b0;
        end
        chk("m_req",   {31'd0, bus.imem_req},    {31'd0, m_phase == 1});
        chk("m_addr",  bus.imem_addr,            m_pc);
        chk("m_valid", {31'd0, bus.instr_valid}, {31'd0, m_phase == 2});
        chk("m_instr", bus.instr,                m_instr);
        chk("m_ipc",   bus.instr_pc,             m_ipc);
        chk("m_mis",   {31'd0, bus.misalign},    {31'd0, m_mis});
        if (rst_n) begin
            if (m_phase == 0) begin
                if (run) m_phase = 1;
            end else if (m_phase == 1) begin
                if (bus.imem_ack) begin
                    m_instr = bus.imem_rdata;
                    m_ipc   = m_pc;
                    m_phase = 2;
                end
            end else begin
                if (bus.instr_ready) begin
                    m_pc = ref_next(m_ipc, bus.branch_taken, bus.branch_offset, bus.jump,
                                    bus.jump_index, bus.jr, bus.jr_target);
`ifdef JR_EN
                    if (bus.jr && (bus.jr_target % 4 != 0)) m_mis = 1'b1;
`endif
                    m_phase = run ? 1 : 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_index    = 26'h0;
        bus.jr            = 1'b0;
        bus.jr_target     = 32'h0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        run = 1'b0;
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        clear_redirects();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.imem_req && n < 100) begin
            step();
            n++;
        end
        if (!bus.imem_req) begin
            fails++;
            tests++;
            $display("FAIL wait_req: got timeout expected imem_req at %0t", $time);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.instr_valid && n < 100) begin
            step();
            n++;
        end
        if (!bus.instr_valid) begin
            fails++;
            tests++;
            $display("FAIL wait_valid: got timeout expected instr_valid at %0t", $time);
        end
    endtask

    task automatic expect_addr(input string name, input logic [31:0] exp);
        wait_req();
        chk(name, bus.imem_addr, exp);
    endtask

    task automatic fetch(input int delay, input logic [31:0] data);
        logic [31:0] a0;
        wait_req();
        a0 = bus.imem_addr;
        for (int i = 0; i < delay; i++) begin
            step();
            chk("hold_req",  {31'd0, bus.imem_req},    32'd1);
            chk("hold_addr", bus.imem_addr,            a0);
            chk("hold_nval", {31'd0, bus.instr_valid}, 32'd0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = ~data;
        chk("cap_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("cap_instr", bus.instr, data);
        chk("cap_ipc",   bus.instr_pc, a0);
    endtask

    task automatic accept(input logic br, input logic [31:0] off, input logic j,
                          input logic [25:0] idx, input logic jrv, input logic [31:0] jt,
                          input logic runv);
        wait_valid();
        bus.instr_ready   = 1'b1;
        bus.branch_taken  = br;
        bus.branch_offset = off;
        bus.jump          = j;
        bus.jump_index    = idx;
        bus.jr            = jrv;
        bus.jr_target     = jt;
        run               = runv;
        step();
        bus.instr_ready = 1'b0;
        clear_redirects();
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        clear_redirects();
        #12;
        chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
        chk("rst_addr",  bus.imem_addr,            32'h0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr,                32'h0);
        chk("rst_ipc",   bus.instr_pc,             32'h0);
        chk("rst_mis",   {31'd0, bus.misalign},    32'd0);
        step();
        rst_n = 1'b1;

        // Back-to-back: immediate ack, decode always ready.
        step();
        run = 1'b1;
        bus.imem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k % 2 == 1) begin
                chk("b2b_req",  {31'd0, bus.imem_req}, 32'd1);
                chk("b2b_addr", bus.imem_addr, 32'(4 * ((k - 1) / 2)));
                chk("b2b_nval", {31'd0, bus.instr_valid}, 32'd0);
            end else begin
                chk("b2b_valid", {31'd0, bus.instr_valid}, 32'd1);
            end
        end

        // Delayed ack and redirect chain.
        do_reset();
        run = 1'b1;
        fetch(3, 32'hDEAD_BEEF);
        accept(1'b0, 32'h0, 1'b1, 26'h0100004, 1'b0, 32'h0, 1'b1);
        expect_addr("jmp1", 32'h0040_0010);
        fetch(0, 32'h1111_0000);
        accept(1'b0, 32'h0, 1'b1, 26'h0100008, 1'b0, 32'h0, 1'b1);
        expect_addr("jmp2", 32'h0040_0020);
        fetch(1, 32'h2222_0000);
        accept(1'b0, 32'h0, 1'b1, 26'h0000040, 1'b0, 32'h0, 1'b1);
        expect_addr("jmp3", 32'h0000_0100);
        fetch(0, 32'h3333_0000);
        accept(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
        expect_addr("br_back", 32'h0000_00FC);
        fetch(2, 32'h4444_0000);
        accept(1'b1, 32'h0000_0010, 1'b1, 26'h0000040, 1'b0, 32'h0, 1'b1);
        expect_addr("br_jmp", 32'h0000_0100);
        fetch(0, 32'h5555_0000);
        accept(1'b1, 32'h0000_0020, 1'b1, 26'h0000080, 1'b1, 32'h0000_1003, 1'b1);
`ifdef JR_EN
        expect_addr("jr_addr", 32'h0000_1000);
        chk("jr_mis", {31'd0, bus.misalign}, 32'd1);
`else
        expect_addr("jr_off", 32'h0000_0200);
        chk("jr_mis", {31'd0, bus.misalign}, 32'd0);
`endif
        fetch(0, 32'h6666_0000);
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_1003, 1'b1);
`ifdef JR_EN
        expect_addr("jr2_addr", 32'h0000_1000);
        chk("mis_sticky", {31'd0, bus.misalign}, 32'd1);
`else
        expect_addr("jr2_seq", 32'h0000_0204);
        chk("mis_tied", {31'd0, bus.misalign}, 32'd0);
`endif

        // Asynchronous reset while a request is outstanding.
        wait_req();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("arst_mis", {31'd0, bus.misalign}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        run = 1'b1;
        expect_addr("restart", 32'h0);

        // Wrap through 0xFFFF_FFFC, then stop fetching from HOLD.
        fetch(0, 32'h7777_0000);
        accept(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
        expect_addr("to_top", 32'hFFFF_FFFC);
        fetch(0, 32'h8888_0000);
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
        expect_addr("wrap0", 32'h0);
        fetch(0, 32'h9999_0000);
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("stop_req", {31'd0, bus.imem_req},    32'd0);
            chk("stop_val", {31'd0, bus.instr_valid}, 32'd0);
            step();
        end
        chk("stop_addr", bus.imem_addr, 32'h4);

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            run               = ($urandom_range(0, 15) != 0);
            bus.imem_ack      = ($urandom_range(0, 2) == 0);
            bus.imem_rdata    = $urandom;
            bus.instr_ready   = ($urandom_range(0, 2) == 0);
            bus.branch_taken  = $urandom_range(0, 1) == 1;
            bus.branch_offset = 32'($signed($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 7) == 0) bus.branch_offset = $urandom;
            bus.jump          = ($urandom_range(0, 3) == 0);
            bus.jump_index    = 26'($urandom);
            bus.jr            = ($urandom_range(0, 4) == 0);
            bus.jr_target     = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
